// File: rtl/ssr_vote_ctrl.sv
// ssr_vote_ctrl: button-armed capture window that majority-votes classifier results and shows the winner on one-hot LEDs.
// Latency: decision_valid/led update NUM_CLASSES cycles after the edge that counts the last vote (or hits the timeout).
// Backpressure: none; result_valid is a strobe, ignored outside COLLECT, and invalid class indices are dropped.
// Ports: clk/rst (sync, active-high), but (raw button), result_valid/result_class (classifier strobe),
//        led (one-hot winner), reject (no decision), decision (held winner), decision_valid (1-cycle pulse),
//        busy (COLLECT or DECIDE).
module ssr_vote_ctrl #(
  parameter int NUM_CLASSES     = 4,
  parameter int VOTES           = 5,
  parameter int MIN_AGREE       = 3,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           but,
  input  logic                           result_valid,
  input  logic [$clog2(NUM_CLASSES)-1:0] result_class,
  output logic [NUM_CLASSES-1:0]         led,
  output logic                           reject,
  output logic [$clog2(NUM_CLASSES)-1:0] decision,
  output logic                           decision_valid,
  output logic                           busy
);

  localparam int CLASS_W = $clog2(NUM_CLASSES);
  localparam int HW      = $clog2(VOTES + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HLW     = $clog2(HOLD_CYCLES + 1);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
  // When NUM_CLASSES is a power of two every encodable index is a real class.
  localparam bit ALL_VALID = ((1 << CLASS_W) == NUM_CLASSES);

  typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, SHOW} state_t;

  // Button synchroniser and debouncer
  logic          sync1_q, sync2_q, stable_q, start_q;
  logic [DW-1:0] db_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      start_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= but;
      sync2_q <= sync1_q;
      start_q <= 1'b0;
      if (sync2_q != stable_q) begin
        if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable_q <= sync2_q;
          db_cnt_q <= '0;
          start_q  <= sync2_q;  // pulse only on the rising stable edge
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Vote collection, argmax scan and display
  state_t               state_q;
  logic [HW-1:0]        hist_q [NUM_CLASSES];
  logic [HW-1:0]        vote_cnt_q, max_q;
  logic [TW-1:0]        to_cnt_q;
  logic [HLW-1:0]       hold_cnt_q;
  logic [CLASS_W-1:0]   scan_idx_q, win_q, decision_q;
  logic [NUM_CLASSES-1:0] led_q;
  logic                 reject_q, dv_q, busy_q;

  logic                 class_ok, vote_ok;
  logic [HW-1:0]        scan_val, nxt_max;
  logic [CLASS_W-1:0]   nxt_win;

  always_comb begin
    class_ok = ALL_VALID ? 1'b1 : (32'(result_class) < NUM_CLASSES);
    vote_ok  = result_valid && class_ok;
    scan_val = hist_q[scan_idx_q];
    // Strictly greater keeps the earlier (lower) index on ties.
    nxt_max  = (scan_val > max_q) ? scan_val : max_q;
    nxt_win  = (scan_val > max_q) ? scan_idx_q : win_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vote_cnt_q <= '0;
      max_q      <= '0;
      to_cnt_q   <= '0;
      hold_cnt_q <= '0;
      scan_idx_q <= '0;
      win_q      <= '0;
      decision_q <= '0;
      led_q      <= '0;
      reject_q   <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) hist_q[i] <= '0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_q) begin
            state_q    <= COLLECT;
            busy_q     <= 1'b1;
            vote_cnt_q <= '0;
            to_cnt_q   <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) hist_q[i] <= '0;
          end
        end
        COLLECT: begin
          if (vote_ok) begin
            hist_q[result_class] <= hist_q[result_class] + 1'b1;
            vote_cnt_q           <= vote_cnt_q + 1'b1;
          end
          if ((vote_ok && vote_cnt_q == HW'(VOTES - 1)) ||
              to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q    <= DECIDE;
            scan_idx_q <= '0;
            max_q      <= '0;
            win_q      <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        DECIDE: begin
          max_q      <= nxt_max;
          win_q      <= nxt_win;
          scan_idx_q <= scan_idx_q + 1'b1;
          if (scan_idx_q == CLASS_W'(NUM_CLASSES - 1)) begin
            if (nxt_max >= HW'(MIN_AGREE)) begin
              decision_q <= nxt_win;
              led_q      <= NUM_CLASSES'(1) << nxt_win;
              reject_q   <= 1'b0;
            end else begin
              led_q    <= '0;
              reject_q <= 1'b1;
            end
            dv_q       <= 1'b1;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            state_q    <= SHOW;
          end
        end
        SHOW: begin
          if (start_q) begin
            // New press restarts the window without waiting out the display.
            led_q      <= '0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b1;
            vote_cnt_q <= '0;
            to_cnt_q   <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) hist_q[i] <= '0;
            state_q    <= COLLECT;
          end else if (hold_cnt_q == HLW'(HOLD_CYCLES - 1)) begin
            led_q    <= '0;
            reject_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign led            = led_q;
  assign reject         = reject_q;
  assign decision       = decision_q;
  assign decision_valid = dv_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ssr_vote_ctrl.sv
// tb_ssr_vote_ctrl: directed stimulus with a scoreboard for ssr_vote_ctrl.
// Instance A: 4 classes, MIN_AGREE=3. Instance B: 6 classes (invalid indices encodable), MIN_AGREE=2.
// Expected decisions are queued at stimulus time and popped by a monitor on each decision_valid pulse.
module tb_ssr_vote_ctrl;

  localparam int TO = 200;
  localparam int HOLD = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       but_a = 1'b0, rv_a = 1'b0;
  logic [1:0] rc_a = '0;
  logic [3:0] led_a;
  logic [1:0] dec_a;
  logic       rej_a, dv_a, busy_a;

  logic       but_b = 1'b0, rv_b = 1'b0;
  logic [2:0] rc_b = '0;
  logic [5:0] led_b;
  logic [2:0] dec_b;
  logic       rej_b, dv_b, busy_b;

  ssr_vote_ctrl #(.NUM_CLASSES(4), .VOTES(5), .MIN_AGREE(3), .TIMEOUT_CYCLES(TO),
                  .HOLD_CYCLES(HOLD), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .but(but_a), .result_valid(rv_a), .result_class(rc_a),
    .led(led_a), .reject(rej_a), .decision(dec_a), .decision_valid(dv_a), .busy(busy_a));

  ssr_vote_ctrl #(.NUM_CLASSES(6), .VOTES(5), .MIN_AGREE(2), .TIMEOUT_CYCLES(TO),
                  .HOLD_CYCLES(HOLD), .DEBOUNCE_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .but(but_b), .result_valid(rv_b), .result_class(rc_b),
    .led(led_b), .reject(rej_b), .decision(dec_b), .decision_valid(dv_b), .busy(busy_b));

  typedef struct {
    logic [5:0] led;
    logic [2:0] dec;
    logic       rej;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_vote = 0;
  int ent = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: compare every decision_valid pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && dv_a) begin
      if (qa.size() == 0) bound_fail("a_unexpected_decision");
      else begin
        ea = qa.pop_front();
        chk("a_decision", 32'(dec_a), 32'(ea.dec));
        chk("a_led", 32'(led_a), 32'(ea.led));
        chk("a_reject", 32'(rej_a), 32'(ea.rej));
        chk("a_latency", cyc, ea.cyc);
        chk("a_busy_in_show", 32'(busy_a), 32'd0);
      end
    end
    if (!rst && dv_b) begin
      if (qb.size() == 0) bound_fail("b_unexpected_decision");
      else begin
        eb = qb.pop_front();
        chk("b_decision", 32'(dec_b), 32'(eb.dec));
        chk("b_led", 32'(led_b), 32'(eb.led));
        chk("b_reject", 32'(rej_b), 32'(eb.rej));
        chk("b_latency", cyc, eb.cyc);
      end
    end
  end

  task automatic push(input bit sel, input logic [5:0] led, input logic [2:0] dec,
                      input logic rej, input int c);
    exp_t e;
    e.led = led; e.dec = dec; e.rej = rej; e.cyc = c;
    if (sel) qb.push_back(e); else qa.push_back(e);
  endtask

  // All tasks start and end at posedge+#1. A vote driven now is sampled at edge cyc+1.
  task automatic send(input bit sel, input int cls);
    if (sel) begin rv_b = 1'b1; rc_b = 3'(cls); end
    else     begin rv_a = 1'b1; rc_a = 2'(cls); end
    if (cls < (sel ? 6 : 4)) last_vote = cyc + 1;
    @(posedge clk); #1;
    rv_a = 1'b0; rv_b = 1'b0;
  endtask

  task automatic hold_but(input bit sel, input int n);
    if (sel) but_b = 1'b1; else but_a = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    but_a = 1'b0; but_b = 1'b0;
  endtask

  // Press until busy rises; ent records the edge on which COLLECT was entered.
  task automatic press_wait(input bit sel);
    bit got = 1'b0;
    if (sel) but_b = 1'b1; else but_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if ((sel ? busy_b : busy_a) === 1'b1) begin got = 1'b1; break; end
    end
    ent = cyc;
    but_a = 1'b0; but_b = 1'b0;
    if (!got) bound_fail(sel ? "b_press_start" : "a_press_start");
  endtask

  task automatic wait_dv(input bit sel);
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if ((sel ? dv_b : dv_a) === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) bound_fail(sel ? "b_decision_wait" : "a_decision_wait");
  endtask

  task automatic idle_out();
    repeat (HOLD + 5) @(posedge clk);
    #1;
  endtask

  int busy_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", 32'(led_a), 32'd0);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_decision", 32'(dec_a), 32'd0);
    chk("reset_reject", 32'(rej_a), 32'd0);
    rst = 1'b0;

    // 1: clear majority for class 2, then LED holds for exactly HOLD cycles.
    hold_but(0, 10);
    press_wait(0);
    send(0, 2); send(0, 2); send(0, 1); send(0, 2); send(0, 0);
    push(0, 6'b000100, 3'd2, 1'b0, last_vote + 4);
    wait_dv(0);
    repeat (HOLD - 1) @(posedge clk);
    #1;
    chk("a_led_last_hold_cycle", 32'(led_a), 32'd4);
    @(posedge clk); #1;
    chk("a_led_after_hold", 32'(led_a), 32'd0);

    // 2: best class has only 2 votes -> reject, decision keeps 2.
    press_wait(0);
    send(0, 1); send(0, 1); send(0, 3); send(0, 3); send(0, 0);
    push(0, 6'b000000, 3'd2, 1'b1, last_vote + 4);
    wait_dv(0);
    idle_out();

    // 2b: same votes with MIN_AGREE=2 -> tie 1 vs 3 resolves to lower index 1.
    press_wait(1);
    send(1, 1); send(1, 1); send(1, 3); send(1, 3); send(1, 0);
    push(1, 6'b000010, 3'd1, 1'b0, last_vote + 6);
    wait_dv(1);
    idle_out();

    // 5: indices 6 and 7 are dropped; five valid votes are still needed.
    press_wait(1);
    send(1, 4); send(1, 7); send(1, 4); send(1, 6); send(1, 5); send(1, 4); send(1, 1);
    push(1, 6'b010000, 3'd4, 1'b0, last_vote + 6);
    wait_dv(1);
    idle_out();

    // 3: three votes then timeout.
    press_wait(0);
    send(0, 3); send(0, 3); send(0, 3);
    push(0, 6'b001000, 3'd3, 1'b0, ent + TO + 4);
    wait_dv(0);
    idle_out();

    // 3b: no votes at all -> reject after timeout.
    press_wait(0);
    push(0, 6'b000000, 3'd3, 1'b1, ent + TO + 4);
    wait_dv(0);
    idle_out();

    // 4: a 2-cycle glitch must not start a window.
    but_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    but_a = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy_a) busy_seen++;
    end
    chk("a_glitch_no_start", busy_seen, 0);

    // 4b: a press in COLLECT does not restart the window (hist keeps the first two 0s).
    press_wait(0);
    send(0, 0); send(0, 0);
    hold_but(0, 10);
    send(0, 0); send(0, 1); send(0, 1);
    push(0, 6'b000001, 3'd0, 1'b0, last_vote + 4);
    wait_dv(0);

    // 4c: a press in SHOW clears the LED and opens a new window at once.
    repeat (5) @(posedge clk);
    #1;
    press_wait(0);
    chk("a_show_press_led", 32'(led_a), 32'd0);
    chk("a_show_press_busy", 32'(busy_a), 32'd1);
    send(0, 1); send(0, 1); send(0, 1); send(0, 2); send(0, 2);
    push(0, 6'b000010, 3'd1, 1'b0, last_vote + 4);
    wait_dv(0);
    idle_out();

    // 6: reset mid-COLLECT.
    press_wait(0);
    send(0, 2); send(0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("a_rst_collect_busy", 32'(busy_a), 32'd0);
    chk("a_rst_collect_decision", 32'(dec_a), 32'd0);
    chk("a_rst_collect_dv", 32'(dv_a), 32'd0);
    press_wait(0);
    send(0, 3); send(0, 3); send(0, 3); send(0, 3); send(0, 3);
    push(0, 6'b001000, 3'd3, 1'b0, last_vote + 4);
    wait_dv(0);

    // 6b: reset mid-SHOW.
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("a_rst_show_led", 32'(led_a), 32'd0);
    chk("a_rst_show_decision", 32'(dec_a), 32'd0);
    chk("a_rst_show_reject", 32'(rej_a), 32'd0);
    chk("a_rst_show_busy", 32'(busy_a), 32'd0);
    press_wait(0);
    send(0, 1); send(0, 1); send(0, 1); send(0, 0); send(0, 0);
    push(0, 6'b000010, 3'd1, 1'b0, last_vote + 4);
    wait_dv(0);

    repeat (5) @(posedge clk);
    #1;
    chk("a_pending_expectations", qa.size(), 0);
    chk("b_pending_expectations", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ssr_vote_ctrl.md
Name: ssr_vote_ctrl

Overview:
Parametrised decision stage between the neural-network classifier and the board indicators of the speech-recognition top level. A debounced button press opens a capture window. The block collects VOTES classifier results, takes a majority vote with a minimum-agreement threshold, and drives a one-hot LED per class for a fixed hold time. It replaces the single-LED indicator logic and generalises it to NUM_CLASSES classes, adding voting, rejection and a timeout.

Parameters:
NUM_CLASSES, 4, number of recognisable classes (2..16); one LED each
CLASS_W, $clog2(NUM_CLASSES), width of class index (derived, not overridden)
VOTES, 5, classifier results collected per window (1..15)
MIN_AGREE, 3, minimum votes the winner needs; fewer gives reject (1..VOTES)
TIMEOUT_CYCLES, 50_000_000, maximum COLLECT duration in clk cycles
HOLD_CYCLES, 100_000_000, LED/reject display time in clk cycles
DEBOUNCE_CYCLES, 1_000_000, cycles the button must be stable to register

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
but  input  1  raw asynchronous push-button, active-high
result_valid  input  1  one-cycle strobe: result_class is valid
result_class  input  CLASS_W  classifier output index
led  output  NUM_CLASSES  one-hot winning class indicator
reject  output  1  high during SHOW when there was no valid decision
decision  output  CLASS_W  winning class, held until the next decision
decision_valid  output  1  one-cycle pulse when decision/reject is updated
busy  output  1  high in COLLECT and DECIDE

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; led=0, reject=0, decision=0, decision_valid=0, busy=0; all counters, histogram and synchroniser flops cleared. Reset asserted in any state aborts that state immediately.
- Button path: 2-flop synchroniser, then debounce counter. The stable level updates after DEBOUNCE_CYCLES consecutive equal samples. A start event is a rising edge of the stable level (1-cycle pulse).
- States:
  - IDLE: start → COLLECT; histogram and vote count cleared on entry.
  - COLLECT: busy=1. Each result_valid with result_class < NUM_CLASSES increments hist[result_class] and the vote count. result_class >= NUM_CLASSES is discarded and not counted. When the vote count reaches VOTES → DECIDE. If the timeout counter reaches TIMEOUT_CYCLES first → DECIDE with the votes gathered so far. Start events are ignored.
  - DECIDE: busy=1. Sequential argmax scan, one class per cycle, index 0 to NUM_CLASSES-1. A strictly-greater comparison means ties go to the lowest index. Takes exactly NUM_CLASSES cycles. result_valid is ignored. On completion:
    - if max >= MIN_AGREE: decision=winner, led=one-hot(winner), reject=0;
    - otherwise: led=0, reject=1, decision unchanged;
    - decision_valid pulses for 1 cycle → SHOW.
  - SHOW: outputs held. After HOLD_CYCLES → IDLE with led=0 and reject=0. A start event in SHOW clears led/reject and goes straight to COLLECT, restarting the window.
- Latency: the last counted vote is on cycle N. Entry to DECIDE is N+1. decision_valid and led update at N+1+NUM_CLASSES.
- Zero votes at timeout: max=0 < MIN_AGREE → reject.
- Histogram counters are $clog2(VOTES+1) bits wide and cannot overflow, since the count is capped at VOTES.
- result_valid on the same cycle as the COLLECT entry is not counted; counting starts the cycle after entry.

Test Plan:
(Sim parameters: NUM_CLASSES=4, VOTES=5, MIN_AGREE=3, TIMEOUT_CYCLES=200, HOLD_CYCLES=50, DEBOUNCE_CYCLES=4.)
1. Press but for 10 cycles, then send classes 2,2,1,2,0 → decision=2, led=4'b0100, reject=0, decision_valid pulse 4 cycles after the 5th vote; led clears 50 cycles later.
2. Send votes 1,1,3,3,0 (max 2 < 3) → reject=1, led=0, decision keeps its previous value; with MIN_AGREE=2 the same votes give a tie resolved to decision=1.
3. Press, then send only 3,3,3 and wait → timeout at 200 cycles, decision=3, led=4'b1000; with no votes at all → reject=1.
4. Glitch but high for 2 cycles → no start, busy stays 0. Press during COLLECT → ignored. Press during SHOW → led=0 and busy=1 the next cycle, new window starts.
5. Inject result_class values alongside valid ones → invalid values are not counted and five valid votes are still required before DECIDE.
6. Assert rst mid-COLLECT and mid-SHOW → all outputs 0 the next cycle, state IDLE, a fresh press works normally.
